// File: rtl/multi_alarm_controller.sv
// Multi-slot alarm engine: queues fired alarms, rings until the switch game is
// solved, and falls back to a bounded number of snoozes when nobody responds.
module multi_alarm_controller #(
    parameter int NUM_ALARMS       = 4,
    parameter int GAME_WIDTH       = 10,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE       = 3,
    parameter int ID_W             = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     minute_tick,
    input  logic [15:0]              current,
    input  logic [16*NUM_ALARMS-1:0] alarm_time,
    input  logic [NUM_ALARMS-1:0]    alarm_en,
    input  logic                     push_m,
    input  logic [GAME_WIDTH-1:0]    game_sw,
    output logic                     ring,
    output logic [1:0]               alarm_state,
    output logic [ID_W-1:0]          active_id,
    output logic [GAME_WIDTH-1:0]    game_target,
    output logic [NUM_ALARMS-1:0]    pending,
    output logic                     dismissed
);
    localparam int CNT_MAX = (SNOOZE_MIN > RING_TIMEOUT_MIN) ? SNOOZE_MIN : RING_TIMEOUT_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SC_W    = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_GAME    = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    state_t                state;
    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] match_q;
    logic [NUM_ALARMS-1:0] rise;
    logic [NUM_ALARMS-1:0] sel_onehot;
    logic [NUM_ALARMS-1:0] pend_clr;
    logic [ID_W-1:0]       sel_id;
    logic                  push_q;
    logic                  pe;
    logic [15:0]           lfsr;
    logic [GAME_WIDTH-1:0] new_target;
    logic [CNT_W-1:0]      min_cnt;
    logic [SC_W-1:0]       snooze_cnt;
    logic                  ring_expire;
    logic                  snooze_expire;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = alarm_en[i] && (current == alarm_time[16*i +: 16]);
    end

    // Lowest pending slot wins when leaving IDLE.
    always_comb begin
        sel_id     = '0;
        sel_onehot = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id        = ID_W'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign rise          = match & ~match_q;
    assign pe            = push_m & ~push_q;
    assign pend_clr      = (state == S_IDLE) ? sel_onehot : '0;
    assign new_target    = (lfsr[GAME_WIDTH-1:0] == '0) ? GAME_WIDTH'(1) : lfsr[GAME_WIDTH-1:0];
    assign ring_expire   = (min_cnt == CNT_W'(RING_TIMEOUT_MIN - 1));
    assign snooze_expire = (min_cnt == CNT_W'(SNOOZE_MIN - 1));
    assign alarm_state   = state;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= S_IDLE;
            ring        <= 1'b0;
            dismissed   <= 1'b0;
            active_id   <= '0;
            game_target <= '0;
            pending     <= '0;
            match_q     <= '0;
            push_q      <= 1'b0;
            min_cnt     <= '0;
            snooze_cnt  <= '0;
            lfsr        <= 16'hACE1;
        end else begin
            match_q   <= match;
            push_q    <= push_m;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            dismissed <= 1'b0;
            // A new fire wins over the clear of the same slot.
            pending   <= (pending & ~pend_clr) | rise;

            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        active_id  <= sel_id;
                        snooze_cnt <= '0;
                        min_cnt    <= '0;
                        state      <= S_RINGING;
                        ring       <= 1'b1;
                    end
                end
                S_RINGING, S_GAME: begin
                    if (pe) begin
                        if (state == S_RINGING) begin
                            game_target <= new_target;
                            min_cnt     <= '0;
                            state       <= S_GAME;
                        end else if (game_sw == game_target) begin
                            dismissed   <= 1'b1;
                            game_target <= '0;
                            state       <= S_IDLE;
                            ring        <= 1'b0;
                        end else begin
                            game_target <= new_target;
                        end
                    end else if (minute_tick) begin
                        if (ring_expire) begin
                            min_cnt <= '0;
                            ring    <= 1'b0;
                            if (snooze_cnt < SC_W'(MAX_SNOOZE)) begin
                                snooze_cnt <= snooze_cnt + SC_W'(1);
                                state      <= S_SNOOZE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            min_cnt <= min_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SNOOZE: begin
                    if (minute_tick) begin
                        if (snooze_expire) begin
                            min_cnt <= '0;
                            state   <= S_RINGING;
                            ring    <= 1'b1;
                        end else begin
                            min_cnt <= min_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_alarm_controller.sv
// Scoreboard bench: a behavioural alarm model queues the expected outputs of every
// cycle and a negedge monitor pops and compares them against the controller.
module tb_multi_alarm_controller;
    localparam int NA   = 4;
    localparam int GW   = 10;
    localparam int SNZ  = 1;
    localparam int RTO  = 2;
    localparam int MAXS = 1;
    localparam int IDW  = 3;

    localparam int IDLE    = 0;
    localparam int RINGING = 1;
    localparam int GAME    = 2;
    localparam int SNOOZE  = 3;

    logic              clk         = 1'b0;
    logic              resetn      = 1'b1;
    logic              minute_tick = 1'b0;
    logic [15:0]       current     = 16'h0000;
    logic [16*NA-1:0]  alarm_time  = '0;
    logic [NA-1:0]     alarm_en    = '0;
    logic              push_m      = 1'b0;
    logic [GW-1:0]     game_sw     = '0;
    logic              ring;
    logic [1:0]        alarm_state;
    logic [IDW-1:0]    active_id;
    logic [GW-1:0]     game_target;
    logic [NA-1:0]     pending;
    logic              dismissed;

    multi_alarm_controller #(
        .NUM_ALARMS(NA), .GAME_WIDTH(GW), .SNOOZE_MIN(SNZ),
        .RING_TIMEOUT_MIN(RTO), .MAX_SNOOZE(MAXS), .ID_W(IDW)
    ) dut (
        .clk(clk), .resetn(resetn), .minute_tick(minute_tick), .current(current),
        .alarm_time(alarm_time), .alarm_en(alarm_en), .push_m(push_m), .game_sw(game_sw),
        .ring(ring), .alarm_state(alarm_state), .active_id(active_id),
        .game_target(game_target), .pending(pending), .dismissed(dismissed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int rng;
        int id;
        int tgt;
        int pend;
        int dis;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;

    int        m_st, m_id, m_mins, m_snoozes, m_tgt;
    bit        m_dis;
    bit        m_pend[NA];
    bit        m_mq[NA];
    bit        m_pq;
    bit [15:0] m_lfsr;

    function automatic bit [15:0] lfsr_step(bit [15:0] x);
        int taps[4] = '{16, 14, 13, 11};
        bit fb = 1'b0;
        foreach (taps[k]) fb ^= x[taps[k] - 1];
        return {x[14:0], fb};
    endfunction

    function automatic int fresh_target(bit [15:0] x);
        int v = int'(x) % (1 << GW);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference model: consumes the inputs seen at each edge and predicts the outputs after it.
    always @(posedge clk) begin
        snap_t s;
        bit    pe;
        bit    hit[NA];
        int    pick;
        if (resetn) begin
            m_st = IDLE; m_id = 0; m_mins = 0; m_snoozes = 0; m_tgt = 0;
            m_dis = 0; m_pq = 0; m_lfsr = 16'hACE1;
            for (int i = 0; i < NA; i++) begin m_pend[i] = 0; m_mq[i] = 0; end
        end else begin
            pe = push_m && !m_pq;
            for (int i = 0; i < NA; i++)
                hit[i] = alarm_en[i] && (current == alarm_time[16*i +: 16]);
            m_dis = 0;
            if (m_st == IDLE) begin
                pick = -1;
                for (int i = 0; i < NA; i++) if (m_pend[i] && pick < 0) pick = i;
                if (pick >= 0) begin
                    m_pend[pick] = 0; m_id = pick; m_snoozes = 0; m_mins = 0; m_st = RINGING;
                end
            end else if (m_st == SNOOZE) begin
                if (minute_tick) begin
                    m_mins++;
                    if (m_mins == SNZ) begin m_mins = 0; m_st = RINGING; end
                end
            end else if (pe) begin
                if (m_st == RINGING) begin
                    m_tgt = fresh_target(m_lfsr); m_mins = 0; m_st = GAME;
                end else if (int'(game_sw) == m_tgt) begin
                    m_dis = 1; m_tgt = 0; m_st = IDLE;
                end else begin
                    m_tgt = fresh_target(m_lfsr);
                end
            end else if (minute_tick) begin
                m_mins++;
                if (m_mins == RTO) begin
                    m_mins = 0;
                    if (m_snoozes < MAXS) begin m_snoozes++; m_st = SNOOZE; end
                    else m_st = IDLE;
                end
            end
            for (int i = 0; i < NA; i++) begin
                if (hit[i] && !m_mq[i]) m_pend[i] = 1;
                m_mq[i] = hit[i];
            end
            m_pq   = push_m;
            m_lfsr = lfsr_step(m_lfsr);
        end
        s.st   = m_st;
        s.rng  = (m_st == RINGING || m_st == GAME) ? 1 : 0;
        s.id   = m_id;
        s.tgt  = m_tgt;
        s.pend = 0;
        for (int i = 0; i < NA; i++) if (m_pend[i]) s.pend |= (1 << i);
        s.dis  = m_dis ? 1 : 0;
        exp_q.push_back(s);
    end

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_output(input snap_t e);
        check_field("alarm_state", 32'(alarm_state), e.st);
        check_field("ring",        32'(ring),        e.rng);
        check_field("active_id",   32'(active_id),   e.id);
        check_field("game_target", 32'(game_target), e.tgt);
        check_field("pending",     32'(pending),     e.pend);
        check_field("dismissed",   32'(dismissed),   e.dis);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        push_m = 1'b1; wait_cycles(1);
        push_m = 1'b0; wait_cycles(1);
    endtask

    task automatic tick();
        minute_tick = 1'b1; wait_cycles(1);
        minute_tick = 1'b0; wait_cycles(1);
    endtask

    task automatic apply_stimulus(input int cycles);
        logic [15:0] times[5] = '{16'h0900, 16'h0915, 16'h1030, 16'h0901, 16'h1111};
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 99) < 3) current = times[$urandom_range(0, 4)];
            minute_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) push_m = ~push_m;
            if ($urandom_range(0, 2) == 0) game_sw = GW'(m_tgt);
            else                           game_sw = GW'($urandom);
            if ($urandom_range(0, 199) == 0) alarm_en = NA'($urandom);
            resetn = ($urandom_range(0, 499) == 0);
            wait_cycles(1);
        end
        minute_tick = 1'b0; push_m = 1'b0; resetn = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        wait_cycles(3);
        resetn = 1'b0;

        // Single alarm on slot 1, then wrong and right answers.
        alarm_time = {16'h2359, 16'h1200, 16'h0730, 16'h0600};
        alarm_en   = 4'b0010;
        current    = 16'h0700;
        wait_cycles(6);
        current = 16'h0730;
        wait_cycles(4);
        press();
        game_sw = GW'(m_tgt ^ 1);
        press();
        game_sw = GW'(m_tgt);
        press();
        wait_cycles(3);

        // Unanswered alarm: one snooze allowed, then abandoned.
        current = 16'h0731; wait_cycles(2);
        current = 16'h0730; wait_cycles(4);
        repeat (5) tick();
        wait_cycles(3);

        // Two slots firing together are serviced lowest first.
        current    = 16'h0800;
        alarm_time = {16'h2359, 16'h0900, 16'h0730, 16'h0900};
        alarm_en   = 4'b0101;
        wait_cycles(2);
        current = 16'h0900; wait_cycles(4);
        press(); game_sw = GW'(m_tgt); press();
        wait_cycles(4);
        press(); game_sw = GW'(m_tgt); press();
        wait_cycles(3);

        // Reset while in GAME with a queued alarm; still-matching slots re-fire.
        current = 16'h0800; wait_cycles(2);
        current = 16'h0900; wait_cycles(4);
        press();
        resetn = 1'b1; wait_cycles(1);
        resetn = 1'b0; wait_cycles(6);

        alarm_time = {16'h0901, 16'h1030, 16'h0915, 16'h0900};
        alarm_en   = 4'b1111;
        apply_stimulus(3000);
        wait_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
